vec_seq_ctrl: RTL and testbench
===============================

VEC_SEQ_CTRL -- requirements
Module: vec_seq_ctrl

Interface
REQ-001 Parameter MAX_CNT, default 31: maximum element count per vector instruction; SHALL fit in cnt width.
REQ-002 Parameter CNT_W, default 5: width of cnt.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request to begin a vector sequence; accepted only when start_ready=1.
REQ-007 start_ready  output  1  high only in IDLE.
REQ-008 vlen  input  32  requested element count; sampled on an accepted start.
REQ-009 rd_base  input  5  base destination register; sampled on an accepted start.
REQ-010 beat_ready  input  1  downstream (memory/writeback) accepts the current element this cycle.
REQ-011 flush  input  1  abort the current sequence.
REQ-012 cnt  output  CNT_W  element index to the EXE stage; 0 means scalar/no vector beat.
REQ-013 write_addr  output  5  destination register for the current element.
REQ-014 stall_pipe  output  1  freezes upstream pipeline stages while a sequence is active.
REQ-015 done  output  1  one-cycle pulse after the last element is accepted.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE: on start=1 with effective length N>0, the FSM SHALL latch rd_base and N, set cnt=1, and enter RUN on the next edge.
REQ-018 Effective length N SHALL be vlen clamped to MAX_CNT; vlen=0 SHALL go from IDLE directly to DONE with no beats issued.
REQ-019 RUN: cnt SHALL hold while beat_ready=0.
REQ-020 RUN: on beat_ready=1 with cnt<N, cnt SHALL increment by 1.
REQ-021 RUN: on beat_ready=1 with cnt==N, the FSM SHALL enter DONE and cnt SHALL return to 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 In RUN, write_addr SHALL equal (latched rd_base + cnt - 1) mod 32, wrapping past register 31 to 0.
REQ-024 Outside RUN, write_addr SHALL equal the latched rd_base.
REQ-025 In IDLE, cnt SHALL be 0.
REQ-026 stall_pipe SHALL be 1 in RUN and on the cycle a start is accepted, and 0 otherwise.
REQ-027 start while not in IDLE SHALL be ignored and SHALL NOT alter the latched rd_base or N.
REQ-028 flush SHALL take priority over every other input in all states.
REQ-029 On flush, the next state SHALL be IDLE with cnt=0, done=0 and stall_pipe=0 from the next cycle.
REQ-030 flush asserted together with start in IDLE SHALL drop the start.
REQ-031 Per-cycle latency: one beat per cycle while beat_ready=1; a sequence of N beats with no back-pressure SHALL take N+1 cycles from the accepted start to done.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, cnt=0, rd_base latch=0, N latch=0, done=0 and stall_pipe=0.
REQ-033 rst asserted mid-sequence SHALL discard the sequence with no done pulse.

Structure
REQ-034 The state encoding (IDLE/RUN/DONE) and MAX_CNT SHALL live in the shared vector processor package.
REQ-035 The block SHALL be one module with no sub-modules; the FSM and counter SHALL be in separate sequential processes.

Verification
REQ-036 Start with vlen=4, rd_base=2, beat_ready=1 -> cnt 1,2,3,4; write_addr 2,3,4,5; done on cycle 5; stall_pipe high for cycles 0-4.
REQ-037 Same as REQ-036 with beat_ready=0 on the cnt=2 cycle for 3 cycles -> cnt holds at 2 and write_addr at 3 for 4 cycles; done is delayed by 3 cycles.
REQ-038 vlen=0 -> no cnt≠0 cycle, done pulses the next cycle; vlen=40 -> exactly 31 beats.
REQ-039 rd_base=30, vlen=4 -> write_addr 30,31,0,1.
REQ-040 Flush at cnt=3 of vlen=6 -> next cycle IDLE, cnt=0, no done, start_ready=1; start asserted during RUN is ignored.
REQ-041 rst asserted at cnt=2 -> all outputs are at reset values immediately; a new start afterward runs normally.

Source files
------------

// File: rtl/vec_seq_ctrl_pkg.sv
// Shared vector-processor definitions: sequencer state encoding and size limits.
package vec_seq_ctrl_pkg;

    localparam int unsigned VEC_MAX_CNT = 31;
    localparam int unsigned VEC_CNT_W   = 5;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned VLEN_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vec_state_e;

endpackage

// File: rtl/vec_seq_ctrl.sv
// Vector sequence controller: turns one vector instruction into a series of
// element beats, stepping the element index and destination register while
// stalling upstream stages.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, start_ready  sequence request / accept (ready only in IDLE)
//   vlen, rd_base       element count and base register, sampled on accept
//   beat_ready          downstream takes the current element this cycle
//   flush               abort, highest priority
//   cnt                 element index (1..N), 0 when no vector beat
//   write_addr          destination register of the current element
//   stall_pipe          freeze upstream while the sequence is active
//   done                one-cycle pulse after the last element
module vec_seq_ctrl
    import vec_seq_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CNT = VEC_MAX_CNT,
    parameter int unsigned CNT_W   = VEC_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  start_ready,
    input  logic [VLEN_W-1:0]     vlen,
    input  logic [REG_ADDR_W-1:0] rd_base,
    input  logic                  beat_ready,
    input  logic                  flush,
    output logic [CNT_W-1:0]      cnt,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic                  stall_pipe,
    output logic                  done
);

    vec_state_e            state;
    logic [REG_ADDR_W-1:0] rd_base_q;
    logic [CNT_W-1:0]      n_q;
    logic [CNT_W-1:0]      n_eff;
    logic                  accept;
    logic                  beat;
    logic                  last_beat;

    // Start qualification and beat decode shared by the FSM and counter
    always_comb begin
        n_eff     = (vlen > VLEN_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : CNT_W'(vlen);
        accept    = (state == ST_IDLE) && start && !flush;
        beat      = (state == ST_RUN) && beat_ready && !flush;
        last_beat = beat && (cnt == n_q);
    end

    assign start_ready = (state == ST_IDLE);
    // Stall covers the accept cycle itself, so it follows the live start input
    assign stall_pipe  = !rst && ((state == ST_RUN) || accept);

    // Sequencer state, instruction latches and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_base_q <= '0;
            n_q       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            rd_base_q <= rd_base;
                            n_q       <= n_eff;
                            if (n_eff == '0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (last_beat) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Element index and destination register; address wraps naturally at 5 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            write_addr <= '0;
        end else if (flush) begin
            cnt        <= '0;
            write_addr <= rd_base_q;
        end else if (accept) begin
            cnt        <= (n_eff == '0) ? CNT_W'(0) : CNT_W'(1);
            write_addr <= rd_base;
        end else if (last_beat) begin
            cnt        <= '0;
            write_addr <= rd_base_q;
        end else if (beat) begin
            cnt        <= cnt + CNT_W'(1);
            write_addr <= write_addr + REG_ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Directed bench for vec_seq_ctrl: per-cycle vector table plus hand-written
// sequences for clamping, flush and mid-sequence reset.
module tb_vec_seq_ctrl;

    typedef struct {
        logic        start;
        logic [31:0] vlen;
        logic [4:0]  rd_base;
        logic        beat_ready;
        logic        flush;
        int          exp_cnt;
        int          exp_wa;
        int          exp_stall;
        int          exp_done;
        int          exp_ready;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start_ready;
    logic [31:0] vlen;
    logic [4:0]  rd_base;
    logic        beat_ready;
    logic        flush;
    logic [4:0]  cnt;
    logic [4:0]  write_addr;
    logic        stall_pipe;
    logic        done;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    vec_seq_ctrl #(.MAX_CNT(31), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_ready(start_ready),
        .vlen       (vlen),
        .rd_base    (rd_base),
        .beat_ready (beat_ready),
        .flush      (flush),
        .cnt        (cnt),
        .write_addr (write_addr),
        .stall_pipe (stall_pipe),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic s, input int vl, input int rb, input logic br,
                               input logic fl, input int c, input int wa, input int st,
                               input int dn, input int rdy);
        vec_t r;
        r.start = s; r.vlen = 32'(vl); r.rd_base = 5'(rb); r.beat_ready = br; r.flush = fl;
        r.exp_cnt = c; r.exp_wa = wa; r.exp_stall = st; r.exp_done = dn; r.exp_ready = rdy;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int wa, input int st,
                           input int dn, input int rdy);
        chk({tag, ".cnt"}, int'(cnt), c);
        chk({tag, ".write_addr"}, int'(write_addr), wa);
        chk({tag, ".stall_pipe"}, int'(stall_pipe), st);
        chk({tag, ".done"}, int'(done), dn);
        chk({tag, ".start_ready"}, int'(start_ready), rdy);
    endtask

    // Drive one cycle's inputs at the falling edge, then sample 1 time unit later
    task automatic drive(input logic s, input int vl, input int rb, input logic br, input logic fl);
        @(negedge clk);
        start = s; vlen = 32'(vl); rd_base = 5'(rb); beat_ready = br; flush = fl;
        #1;
    endtask

    initial begin
        int beats;
        int max_cnt;
        bit seen_done;

        rst = 1'b1; start = 1'b0; vlen = '0; rd_base = '0; beat_ready = 1'b0; flush = 1'b0;
        #1;
        chk_all("reset", 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // vlen=4 rd_base=2, no back-pressure
        tbl.push_back(v(1, 4, 2, 1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 2, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 3, 4, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 4, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 2, 0, 0, 1));
        // Same with 3 cycles of back-pressure at cnt=2
        tbl.push_back(v(1, 4, 2, 1, 0, 0, 2, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 2, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 3, 4, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 4, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 2, 0, 0, 1));
        // Register wrap: rd_base=30
        tbl.push_back(v(1, 4, 30, 1, 0, 0, 2, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 30, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 31, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 3, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 4, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 30, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 30, 0, 0, 1));
        // vlen=0: straight to DONE
        tbl.push_back(v(1, 0, 7, 1, 0, 0, 30, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 7, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 7, 0, 0, 1));
        // flush with start in IDLE drops the start
        tbl.push_back(v(1, 3, 9, 1, 1, 0, 7, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 7, 0, 0, 1));
        // vlen=6 rd_base=4; start during RUN ignored; flush at cnt=3
        tbl.push_back(v(1, 6, 4, 1, 0, 0, 7, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 4, 1, 0, 0));
        tbl.push_back(v(1, 2, 20, 1, 0, 2, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 3, 6, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 4, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 4, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].start, int'(tbl[i].vlen), int'(tbl[i].rd_base), tbl[i].beat_ready, tbl[i].flush);
            chk_all($sformatf("row%0d", i), tbl[i].exp_cnt, tbl[i].exp_wa,
                    tbl[i].exp_stall, tbl[i].exp_done, tbl[i].exp_ready);
        end

        // vlen=40 clamps to 31 beats
        drive(1, 40, 0, 1, 0);
        beats = 0; max_cnt = 0; seen_done = 0;
        for (int k = 0; k < 60 && !seen_done; k++) begin
            drive(0, 0, 0, 1, 0);
            if (cnt != 0) beats++;
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
            if (cnt == 5'd31) chk("clamp.write_addr_at_31", int'(write_addr), 30);
            if (done) seen_done = 1;
        end
        chk("clamp.done_seen", int'(seen_done), 1);
        chk("clamp.beats", beats, 31);
        chk("clamp.max_cnt", max_cnt, 31);
        drive(0, 0, 0, 1, 0);

        // Reset mid-sequence at cnt=2
        drive(1, 5, 10, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("rstseq.cnt1", int'(cnt), 1);
        drive(0, 0, 0, 1, 0);
        chk("rstseq.cnt2", int'(cnt), 2);
        #1;
        rst = 1'b1;
        #1;
        chk_all("rst_mid", 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0);
            if (done || cnt != 0) seen_done = 1;
        end
        chk("rst_mid.no_done_or_beat", int'(seen_done), 0);
        drive(1, 2, 3, 1, 0);
        chk_all("after_rst.accept", 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0);
        chk_all("after_rst.b1", 1, 3, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk_all("after_rst.b2", 2, 4, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk_all("after_rst.done", 0, 3, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk_all("after_rst.idle", 0, 3, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
